hall_conditioner: RTL and testbench

Front-end stage for the motor position path. Takes the two raw hall-effect sensor lines from the motor, synchronises and debounces them, and decodes quadrature direction. It drives clean `hall_1`/`hall_2`/`clockwise` into `angle_tracking_unit`, with `clockwise` guaranteed stable before every hall edge it qualifies. It also flags illegal sensor transitions and a stalled motor.

---
 rtl/hall_conditioner_if.sv | 13 +
 rtl/hall_conditioner.sv | 66 ++++++
 tb/tb_hall_conditioner.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hall_conditioner_if.sv
// hall_conditioner_if: raw hall sensor inputs and conditioned position outputs
interface hall_conditioner_if;
  logic hall_1_raw, hall_2_raw, clear_err;
  logic hall_1, hall_2, clockwise, edge_valid, dir_error, stalled;
  modport master(
    output hall_1_raw, hall_2_raw, clear_err,
    input hall_1, hall_2, clockwise, edge_valid, dir_error, stalled
  );
  modport slave(
    input hall_1_raw, hall_2_raw, clear_err,
    output hall_1, hall_2, clockwise, edge_valid, dir_error, stalled
  );
endinterface

// File: rtl/hall_conditioner.sv
// hall_conditioner: synchronise, debounce and quadrature-decode the two hall sensor lines
module hall_conditioner #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int STALL_CYCLES = 1000000
) (
  input logic CLK,
  input logic reset,
  hall_conditioner_if.slave bus
);
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [8:0] PRIME_LAST = 9'(DEBOUNCE_CYCLES + 1);
  localparam logic [23:0] STALL_LIM = 24'(STALL_CYCLES);
  logic [1:0] meta, sync, db, db_prev, db_next;
  logic [1:0][7:0] cnt, cnt_next;
  logic [8:0] prime_cnt;
  logic primed, cw_step, acw_step, bad_step, legal;
  logic [23:0] stall_cnt;
  for (genvar c = 0; c < 2; c++) begin : g_ch
    assign db_next[c] = (sync[c] != db[c] && cnt[c] == DB_LAST) ? sync[c] : db[c];
    assign cnt_next[c] = (sync[c] == db[c] || cnt[c] == DB_LAST) ? 8'd0 : cnt[c] + 8'd1;
  end
  // bit 1 is hall_1, bit 0 is hall_2; one gray step forward or back
  assign cw_step = db == {~db_prev[0], db_prev[1]};
  assign acw_step = db == {db_prev[0], ~db_prev[1]};
  assign bad_step = (db ^ db_prev) == 2'b11;
  assign legal = cw_step | acw_step;
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      sync <= '0;
      db <= '0;
      db_prev <= '0;
      cnt <= '0;
      prime_cnt <= '0;
      primed <= 1'b0;
      stall_cnt <= '0;
      bus.hall_1 <= 1'b0;
      bus.hall_2 <= 1'b0;
      bus.clockwise <= 1'b1;
      bus.edge_valid <= 1'b0;
      bus.dir_error <= 1'b0;
      bus.stalled <= 1'b0;
    end else begin
      meta <= {bus.hall_1_raw, bus.hall_2_raw};
      sync <= meta;
      db_prev <= db;
      {bus.hall_1, bus.hall_2} <= db_prev;
      if (!primed) begin
        db <= sync;
        cnt <= '0;
        prime_cnt <= prime_cnt + 9'd1;
        primed <= prime_cnt == PRIME_LAST;
        stall_cnt <= '0;
        bus.edge_valid <= 1'b0;
      end else begin
        db <= db_next;
        cnt <= cnt_next;
        bus.edge_valid <= legal;
        bus.clockwise <= legal ? cw_step : bus.clockwise;
        stall_cnt <= legal ? 24'd0 : stall_cnt + {23'd0, stall_cnt != '1};
      end
      bus.dir_error <= (primed & bad_step) | (bus.dir_error & ~bus.clear_err);
      bus.stalled <= stall_cnt >= STALL_LIM;
    end
  end
endmodule

// File: tb/tb_hall_conditioner.sv
// tb_hall_conditioner: directed hall sequences with a queue-based edge_valid scoreboard
module tb_hall_conditioner;
  logic CLK = 0;
  logic reset = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {logic cw; logic [1:0] prev; logic [1:0] hall; int at;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic hall_due = 0;
  logic [1:0] hall_exp;
  hall_conditioner_if bus();
  hall_conditioner #(.DEBOUNCE_CYCLES(8), .STALL_CYCLES(50)) dut (
    .CLK(CLK),
    .reset(reset),
    .bus(bus)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // each pulse must carry its direction and precede the hall edge by one cycle
  always @(negedge CLK) begin
    if (hall_due) begin
      chk("hall_after_pulse", int'({bus.hall_1, bus.hall_2}), int'(hall_exp));
      hall_due = 0;
    end
    if (bus.edge_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_edge_valid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("pulse_cycle", cyc, mon_e.at);
        chk("clockwise_at_pulse", int'(bus.clockwise), int'(mon_e.cw));
        chk("hall_before_edge", int'({bus.hall_1, bus.hall_2}), int'(mon_e.prev));
        hall_exp = mon_e.hall;
        hall_due = 1;
      end
    end
  end
  task automatic drive(input logic [1:0] v, input bit pulse, input logic cw, input logic [1:0] prev);
    @(posedge CLK);
    #1;
    {bus.hall_1_raw, bus.hall_2_raw} = v;
    if (pulse) q.push_back('{cw, prev, v, cyc + 11});
  endtask
  task automatic step(input logic [1:0] v, input logic cw, input logic [1:0] prev);
    drive(v, 1, cw, prev);
    repeat (19) @(posedge CLK);
  endtask
  task automatic at_neg(input int c);
    while (cyc < c) @(negedge CLK);
  endtask
  task automatic reset_to(input logic [1:0] v, output int r);
    {bus.hall_1_raw, bus.hall_2_raw} = v;
    @(posedge CLK);
    #1 reset = 0;
    repeat (5) @(posedge CLK);
    #1 reset = 1;
    r = cyc;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int r, n;
    bus.hall_1_raw = 1;
    bus.hall_2_raw = 1;
    bus.clear_err = 0;
    repeat (5) @(posedge CLK);
    #1;
    chk("rst_hall", int'({bus.hall_1, bus.hall_2}), 0);
    chk("rst_clockwise", int'(bus.clockwise), 1);
    chk("rst_edge_valid", int'(bus.edge_valid), 0);
    chk("rst_dir_error", int'(bus.dir_error), 0);
    chk("rst_stalled", int'(bus.stalled), 0);
    reset = 1;
    r = cyc;
    @(negedge CLK);
    chk("release_hall", int'({bus.hall_1, bus.hall_2}), 0);
    chk("release_clockwise", int'(bus.clockwise), 1);
    at_neg(r + 10);
    chk("primed_hall", int'({bus.hall_1, bus.hall_2}), 3);
    chk("primed_dir_error", int'(bus.dir_error), 0);
    reset_to(2'b00, r);
    at_neg(r + 15);
    step(2'b10, 1, 2'b00);
    step(2'b11, 1, 2'b10);
    step(2'b01, 1, 2'b11);
    step(2'b00, 1, 2'b01);
    step(2'b01, 0, 2'b00);
    step(2'b11, 0, 2'b01);
    chk("reversal_dir_error", int'(bus.dir_error), 0);
    step(2'b10, 0, 2'b11);
    step(2'b00, 0, 2'b10);
    drive(2'b10, 0, 0, 2'b00);
    repeat (4) @(posedge CLK);
    drive(2'b00, 0, 0, 2'b00);
    repeat (19) @(posedge CLK);
    @(negedge CLK);
    chk("glitch5_hall", int'({bus.hall_1, bus.hall_2}), 0);
    drive(2'b10, 1, 1, 2'b00);
    repeat (8) @(posedge CLK);
    drive(2'b00, 1, 0, 2'b10);
    repeat (19) @(posedge CLK);
    @(negedge CLK);
    chk("glitch9_hall", int'({bus.hall_1, bus.hall_2}), 0);
    drive(2'b11, 0, 0, 2'b00);
    n = cyc;
    at_neg(n + 15);
    chk("illegal_dir_error", int'(bus.dir_error), 1);
    chk("illegal_clockwise", int'(bus.clockwise), 0);
    chk("illegal_hall", int'({bus.hall_1, bus.hall_2}), 3);
    @(posedge CLK);
    #1 bus.clear_err = 1;
    @(posedge CLK);
    #1 bus.clear_err = 0;
    @(negedge CLK);
    chk("cleared_dir_error", int'(bus.dir_error), 0);
    reset_to(2'b11, r);
    at_neg(r + 60);
    chk("stall_before", int'(bus.stalled), 0);
    at_neg(r + 61);
    chk("stall_asserted", int'(bus.stalled), 1);
    drive(2'b10, 1, 0, 2'b11);
    n = cyc;
    at_neg(n + 11);
    chk("stall_at_pulse", int'(bus.stalled), 1);
    at_neg(n + 12);
    chk("stall_dropped", int'(bus.stalled), 0);
    at_neg(n + 70);
    chk("stall_again", int'(bus.stalled), 1);
    chk("stall_clockwise", int'(bus.clockwise), 0);
    #2 reset = 0;
    #1;
    chk("async_rst_stalled", int'(bus.stalled), 0);
    chk("async_rst_clockwise", int'(bus.clockwise), 1);
    chk("async_rst_edge_valid", int'(bus.edge_valid), 0);
    repeat (3) @(posedge CLK);
    #1 reset = 1;
    repeat (5) @(posedge CLK);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
